// File: rtl/pcm_sequencer.sv
// Captures one PCM frame per en_pcm strobe and streams the enabled channels over valid/ready.
// Optional PCM_SEQ_TAG_EN adds the out_ch channel-index output.
module pcm_sequencer #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 16,
  parameter int unsigned CHW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_pcm,
  input  logic [NCH*W-1:0] pcm_in,
  input  logic [NCH-1:0]   ch_mask,
  output logic [W-1:0]     out_data,
`ifdef PCM_SEQ_TAG_EN
  output logic [CHW-1:0]   out_ch,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q;
  logic [NCH*W-1:0] snap_q;
  logic [NCH-1:0]   mask_q;
  logic [CHW-1:0]   idx_q;

  // Lowest set bit of m at or above position from.
  function automatic logic [CHW-1:0] lowest_from(input logic [NCH-1:0] m, input int from);
    lowest_from = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (m[k] && k >= from) lowest_from = CHW'(k);
    end
  endfunction

  function automatic logic [CHW-1:0] highest(input logic [NCH-1:0] m);
    highest = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (m[k]) highest = CHW'(k);
    end
  endfunction

  logic           xfer, last_xfer, frame_req, capture, set_ovr;
  logic [CHW-1:0] first_idx, next_idx;
  logic           first_last, next_last;

  always_comb begin
    xfer       = out_valid && out_ready;
    last_xfer  = xfer && out_last;
    frame_req  = en_pcm && (|ch_mask);
    capture    = frame_req && (state_q == StIdle || last_xfer);
    // A non-empty frame that cannot be captured can only arrive mid-frame.
    set_ovr    = frame_req && !capture;
    first_idx  = lowest_from(ch_mask, 0);
    first_last = (first_idx == highest(ch_mask));
    next_idx   = lowest_from(mask_q, int'(idx_q) + 1);
    next_last  = (next_idx == highest(mask_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      out_data  <= '0;
`ifdef PCM_SEQ_TAG_EN
      out_ch    <= '0;
`endif
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_ovr) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if (capture) begin
        state_q   <= StSend;
        snap_q    <= pcm_in;
        mask_q    <= ch_mask;
        idx_q     <= first_idx;
        out_data  <= pcm_in[first_idx*W +: W];
`ifdef PCM_SEQ_TAG_EN
        out_ch    <= first_idx;
`endif
        out_last  <= first_last;
        out_valid <= 1'b1;
        busy      <= 1'b1;
      end else if (xfer) begin
        if (out_last) begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end else begin
          idx_q    <= next_idx;
          out_data <= snap_q[next_idx*W +: W];
`ifdef PCM_SEQ_TAG_EN
          out_ch   <= next_idx;
`endif
          out_last <= next_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_sequencer.sv
// Self-checking bench for pcm_sequencer: directed table, hand sequences and a queue-based
// reference model under random stimulus.
module tb_pcm_sequencer;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CHW = 2;
  localparam logic [NCH*W-1:0] PA = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
  localparam logic [NCH*W-1:0] PB = {16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa};

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en_pcm = 1'b0;
  logic [NCH*W-1:0] pcm_in = '0;
  logic [NCH-1:0]   ch_mask = '0;
  logic             out_ready = 1'b0;
  logic             clr_overrun = 1'b0;
  logic [W-1:0]     out_data;
`ifdef PCM_SEQ_TAG_EN
  logic [CHW-1:0]   out_ch;
`endif
  logic             out_valid, out_last, busy, overrun;

  pcm_sequencer #(.NCH(NCH), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_pcm     (en_pcm),
    .pcm_in     (pcm_in),
    .ch_mask    (ch_mask),
    .out_data   (out_data),
`ifdef PCM_SEQ_TAG_EN
    .out_ch     (out_ch),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: the words still owed to the sink for the current frame, in order.
  typedef struct {
    logic [W-1:0]   data;
    logic [CHW-1:0] ch;
    logic           last;
  } word_t;
  word_t q[$];
  logic  m_ovr = 1'b0;

  typedef struct {
    logic             en;
    logic [NCH-1:0]   m;
    logic [NCH*W-1:0] p;
    logic             rdy;
    logic             valid;
    logic [W-1:0]     data;
    logic             last;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int   sz;
    logic xfer, req, cap;
    int   hi;
    word_t w;
    sz   = q.size();
    xfer = (sz != 0) && out_ready;
    req  = en_pcm && (ch_mask != '0);
    cap  = req && (sz == 0 || (xfer && sz == 1));
    if (xfer) void'(q.pop_front());
    if (cap) begin
      hi = 0;
      for (int k = 0; k < NCH; k++) if (ch_mask[k]) hi = k;
      for (int k = 0; k < NCH; k++) begin
        if (ch_mask[k]) begin
          w.data = pcm_in[k*W +: W];
          w.ch   = CHW'(k);
          w.last = (k == hi);
          q.push_back(w);
        end
      end
    end
    if (req && !cap) m_ovr = 1'b1;
    else if (clr_overrun) m_ovr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, " busy"}, 32'(busy), 32'(q.size() != 0));
    chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
    if (q.size() != 0) begin
      chk({tag, " data"}, 32'(out_data), 32'(q[0].data));
      chk({tag, " last"}, 32'(out_last), 32'(q[0].last));
`ifdef PCM_SEQ_TAG_EN
      chk({tag, " ch"}, 32'(out_ch), 32'(q[0].ch));
`endif
    end else begin
      chk({tag, " last_idle"}, 32'(out_last), 32'd0);
    end
  endtask

  task automatic cyc(input logic en, input logic [NCH-1:0] m, input logic [NCH*W-1:0] p,
                     input logic rdy, input logic clr, input string tag);
    en_pcm      = en;
    ch_mask     = m;
    pcm_in      = p;
    out_ready   = rdy;
    clr_overrun = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'hf, PA, 1'b1, 1'b1, 16'h1111, 1'b0};
    tbl[1] = '{1'b0, 4'h0, PB, 1'b1, 1'b1, 16'h2222, 1'b0};
    tbl[2] = '{1'b0, 4'h3, PB, 1'b1, 1'b1, 16'h3333, 1'b0};
    tbl[3] = '{1'b0, 4'h0, PB, 1'b1, 1'b1, 16'h4444, 1'b1};
    tbl[4] = '{1'b0, 4'h0, PB, 1'b1, 1'b0, 16'h4444, 1'b0};
    tbl[5] = '{1'b1, 4'h0, PB, 1'b1, 1'b0, 16'h4444, 1'b0};

    // Reset values
    #12;
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    chk("rst last", 32'(out_last), 32'd0);
    chk("rst data", 32'(out_data), 32'd0);
`ifdef PCM_SEQ_TAG_EN
    chk("rst ch", 32'(out_ch), 32'd0);
`endif
    reset = 1'b1;

    // Full mask, ready high: table-driven
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].en, tbl[i].m, tbl[i].p, tbl[i].rdy, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("tbl%0d data", i), 32'(out_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d last", i), 32'(out_last), 32'(tbl[i].last));
    end

    // Sparse mask with backpressure; mask changes mid-frame must be ignored
    cyc(1'b1, 4'b1010, PA, 1'b0, 1'b0, "sp0");
    chk("sp0 data", 32'(out_data), 32'h2222);
    cyc(1'b0, 4'b0001, PB, 1'b0, 1'b0, "sp1");
    chk("sp1 hold", 32'(out_data), 32'h2222);
    cyc(1'b0, 4'b0101, PB, 1'b1, 1'b0, "sp2");
    chk("sp2 data", 32'(out_data), 32'h4444);
    chk("sp2 last", 32'(out_last), 32'd1);
    cyc(1'b0, 4'b0000, PB, 1'b0, 1'b0, "sp3");
    chk("sp3 hold", 32'(out_data), 32'h4444);
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b0, "sp4");
    chk("sp4 done", 32'(out_valid), 32'd0);

    // Empty mask is ignored
    cyc(1'b1, 4'b0000, PA, 1'b1, 1'b0, "empty");
    chk("empty busy", 32'(busy), 32'd0);
    chk("empty ovr", 32'(overrun), 32'd0);

    // Overrun while stalled; set beats clear on the same edge
    cyc(1'b1, 4'b1111, PA, 1'b0, 1'b0, "ov0");
    cyc(1'b1, 4'b1111, PB, 1'b0, 1'b0, "ov1");
    chk("ov1 flag", 32'(overrun), 32'd1);
    chk("ov1 data", 32'(out_data), 32'h1111);
    cyc(1'b1, 4'b1111, PB, 1'b0, 1'b1, "ov2");
    chk("ov2 set wins", 32'(overrun), 32'd1);
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b0, "ov3");
    chk("ov3 snapshot", 32'(out_data), 32'h2222);
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b1, "ov4");
    chk("ov4 clear", 32'(overrun), 32'd0);
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b0, "ov5");
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b0, "ov6");

    // Back-to-back frame on the last-word transfer
    cyc(1'b1, 4'b0011, PA, 1'b1, 1'b0, "bb0");
    cyc(1'b0, 4'b0000, PA, 1'b1, 1'b0, "bb1");
    chk("bb1 last", 32'(out_last), 32'd1);
    cyc(1'b1, 4'b0100, PB, 1'b1, 1'b0, "bb2");
    chk("bb2 valid", 32'(out_valid), 32'd1);
    chk("bb2 data", 32'(out_data), 32'hcccc);
    chk("bb2 ovr", 32'(overrun), 32'd0);
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b0, "bb3");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) == 0), NCH'($urandom), {$urandom, $urandom},
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0), $sformatf("rnd%0d", i));
    end

    // Mid-frame reset aborts asynchronously
    cyc(1'b1, 4'b1111, PA, 1'b0, 1'b0, "mr0");
    cyc(1'b1, 4'b1111, PB, 1'b0, 1'b0, "mr1");
    #2 reset = 1'b0;
    #1;
    chk("mr valid", 32'(out_valid), 32'd0);
    chk("mr busy", 32'(busy), 32'd0);
    chk("mr overrun", 32'(overrun), 32'd0);
    q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    cyc(1'b1, 4'b0110, PB, 1'b1, 1'b0, "mr2");
    chk("mr2 data", 32'(out_data), 32'hbbbb);
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b0, "mr3");
    chk("mr3 data", 32'(out_data), 32'hcccc);
    cyc(1'b0, 4'b0000, PB, 1'b1, 1'b0, "mr4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcm_sequencer.md
# pcm_sequencer

Collects one decimated PCM frame from an array of `cic` channels on every `en_pcm` strobe from `audio_clock` and sequences the enabled channels, one word at a time, onto a single valid/ready output stream. It sits between the CIC bank and any downstream sink (FIFO, I2S/USB framer, memory writer), so that one consumer shares the whole decimator array. It also flags lost frames when the sink drains more slowly than the PCM rate.

## Interface
Parameters:
- `NCH`, 4: number of CIC channels (2..16).
- `W`, 16: PCM sample width, matching the `cic` output.
- `CHW`, `$clog2(NCH)`: channel index width (derived; do not override).

Ports:
- `clk`  in  1  system clock; same clock as `audio_clock` and `cic`.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately; deassertion is synchronous to the design.
- `en_pcm`  in  1  single-cycle frame strobe from `audio_clock`.
- `pcm_in`  in  NCH*W  flattened CIC outputs; channel k occupies bits `[k*W +: W]`.
- `ch_mask`  in  NCH  channel enable mask; bit k enables channel k. Sampled only at frame capture.
- `out_data`  out  W  current sample.
- `out_ch`  out  CHW  channel index of `out_data`. Present only with `PCM_SEQ_TAG_EN`.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the word. A transfer occurs on a clock edge where `out_valid && out_ready`.
- `out_last`  out  1  the current word is the last enabled channel of the frame.
- `busy`  out  1  a frame is in progress (state SEND).
- `overrun`  out  1  sticky lost-frame flag.
- `clr_overrun`  in  1  synchronous clear for `overrun`.

## Operation
- The block has two states, IDLE and SEND.
- **Frame capture.** In IDLE, `en_pcm=1` with a nonzero `ch_mask`:
  - latch all NCH samples into the snapshot registers and latch the mask;
  - set `idx` to the lowest set mask bit;
  - go to SEND.
- **Empty mask.** `en_pcm` with `ch_mask==0` is ignored: no state change, no overrun.
- **SEND.**
  - `out_valid=1`, `out_data=snap[idx]`, and `out_last=1` when `idx` is the highest enabled bit.
  - On a transfer, `idx` advances to the next set bit above it and skips disabled channels in zero cycles.
  - A transfer on the last word returns the block to IDLE.
- **Holding.** While `out_ready=0`, `out_data`, `out_ch` and `out_last` hold stable. `out_valid` never drops without a transfer.
- **Overrun.**
  - `en_pcm` in SEND, without a last-word transfer on the same edge, sets `overrun`.
  - The new frame is dropped and the snapshot is untouched.
- **Back-to-back frame.** `en_pcm` on the same edge as the last-word transfer captures the new frame and stays in SEND with no bubble and no overrun.
- **Overrun flag priority.** `clr_overrun` and a new overrun on the same edge leave `overrun=1` (set wins).
- **Mask timing.** Changes to `ch_mask` during SEND have no effect until the next capture.

## Timing
- **Reset values:**
  - state IDLE;
  - `out_valid=0`, `out_last=0`, `busy=0`, `overrun=0`;
  - `out_data=0`, `out_ch=0`, snapshot 0.
- **Capture latency.** `en_pcm` sampled at edge N gives `out_valid=1` from just after edge N, with the first word present.
- **Throughput.** One word per cycle while `out_ready=1`. A full frame of M enabled channels takes exactly M cycles.
- **Registered outputs.** All outputs come from registers; there is no combinational path from `out_ready` to any output.
- **Mid-frame reset.** A reset in the middle of a frame aborts it: `out_valid` drops asynchronously and the remaining words are discarded.

## Configuration
- Macro `PCM_SEQ_TAG_EN`.
- **Defined:** the `out_ch` port exists and carries `idx` registered alongside `out_data`.
- **Undefined:**
  - the `out_ch` port and its register are omitted;
  - the sink infers the channel from word order within a frame, delimited by `out_last`;
  - all other behaviour is identical.

## Test plan
- **Reset.** Assert `reset=0` mid-SEND -> `out_valid`, `busy` and `overrun` read 0 immediately. After release, the next `en_pcm` produces a fresh frame.
- **Full mask, ready high.**
  - Setup: NCH=4, mask `4'b1111`, `pcm_in` = {16'h4444, 16'h3333, 16'h2222, 16'h1111}, `out_ready=1`.
  - Expected: 1111, 2222, 3333, 4444 on 4 consecutive cycles; `out_ch` 0..3; `out_last` only on 4444.
- **Sparse mask with backpressure.**
  - Setup: mask `4'b1010`, `out_ready` toggling 0/1.
  - Expected: only ch1 then ch3; data held stable while stalled; `out_last` on ch3.
- **Overrun.** Stall with `out_ready=0` and pulse `en_pcm` again -> `overrun=1` and the original snapshot still emitted. Then `clr_overrun=1` -> `overrun=0`.
- **Back-to-back.** `en_pcm` on the same edge as the last transfer -> next frame's first word on the following cycle, `overrun` stays 0.
- **Empty mask.** `ch_mask=0` with `en_pcm` -> `busy`, `out_valid` and `overrun` remain 0.
